// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter sharing the read/write port 0 of the 1rw1r SRAM macro
// between requesters A and B, with registered macro pins and read-response routing.
module sram_port0_arbiter #(
   parameter int NUM_WMASKS = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_we,
   input  logic [NUM_WMASKS-1:0] a_req_wmask,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_data,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic                  b_req_we,
   input  logic [NUM_WMASKS-1:0] b_req_wmask,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   output logic                  b_rsp_valid,
   output logic [DATA_WIDTH-1:0] b_rsp_data,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int TAGS = RD_LATENCY + 1;

   logic                  r_ptr_b;
   logic [TAGS-1:0]       r_tag_vld;
   logic [TAGS-1:0]       r_tag_b;

   logic                  w_grant_a;
   logic                  w_grant_b;
   logic                  w_grant;
   logic                  w_we;
   logic [NUM_WMASKS-1:0] w_wmask;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_rsp_hit;

   always_comb begin
      w_grant_a = a_req_valid & (~b_req_valid | ~r_ptr_b);
      w_grant_b = b_req_valid & (~a_req_valid | r_ptr_b);
      w_grant   = w_grant_a | w_grant_b;
      w_we      = w_grant_b ? b_req_we    : a_req_we;
      w_wmask   = w_grant_b ? b_req_wmask : a_req_wmask;
      w_addr    = w_grant_b ? b_req_addr  : a_req_addr;
      w_wdata   = w_grant_b ? b_req_wdata : a_req_wdata;
   end

   assign a_req_ready = w_grant_a;
   assign b_req_ready = w_grant_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr_b     <= 1'b0;
         r_tag_vld   <= '0;
         r_tag_b     <= '0;
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
      end else begin
         // Priority goes to whoever lost; it only moves on a grant.
         if (w_grant) begin
            r_ptr_b <= w_grant_a;
         end
         sram_csb0 <= ~w_grant;
         sram_web0 <= w_grant ? ~w_we : 1'b1;
         if (w_grant) begin
            sram_addr0 <= w_addr;
            if (w_we) begin
               sram_din0   <= w_wdata;
               sram_wmask0 <= w_wmask;
            end else begin
               sram_wmask0 <= '0;
            end
         end
         // Slot k holds the read whose pins are on the macro k cycles ago.
         r_tag_vld <= {r_tag_vld[TAGS-2:0], w_grant & ~w_we};
         r_tag_b   <= {r_tag_b[TAGS-2:0], w_grant_b};
      end
   end

   assign w_rsp_hit   = r_tag_vld[RD_LATENCY];
   assign a_rsp_valid = w_rsp_hit & ~r_tag_b[RD_LATENCY];
   assign b_rsp_valid = w_rsp_hit &  r_tag_b[RD_LATENCY];
   assign a_rsp_data  = a_rsp_valid ? sram_dout0 : '0;
   assign b_rsp_data  = b_rsp_valid ? sram_dout0 : '0;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Directed vector bench for sram_port0_arbiter with a behavioural port-0 SRAM.
module tb_sram_port0_arbiter;

   typedef struct packed {
      logic        v;
      logic        we;
      logic [3:0]  m;
      logic [7:0]  a;
      logic [31:0] d;
   } cmd_t;

   typedef struct {
      cmd_t        ca;
      cmd_t        cb;
      logic        ear;
      logic        ebr;
      logic        ecsb;
      logic        eweb;
      logic [3:0]  ewm;
      logic        earv;
      logic [31:0] eard;
      logic        ebrv;
      logic [31:0] ebrd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
   logic [3:0]  a_req_wmask;
   logic [7:0]  a_req_addr;
   logic [31:0] a_req_wdata, a_rsp_data;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
   logic [3:0]  b_req_wmask;
   logic [7:0]  b_req_addr;
   logic [31:0] b_req_wdata, b_rsp_data;
   logic        sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [7:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0 = 32'h0;

   int n_chk  = 0;
   int n_fail = 0;
   int row    = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   sram_port0_arbiter #(
      .NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(1)
   ) dut (
      .clk(clk), .rst(rst),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   // Macro model: unwritten words read as 0x1000_0000 + address; one-cycle read.
   logic [31:0] mem [0:255];
   bit   [255:0] mem_wr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = din[8*k +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            mem[sram_addr0]    <= merge(mem_wr[sram_addr0] ? mem[sram_addr0]
                                        : 32'h1000_0000 + {24'h0, sram_addr0},
                                        sram_din0, sram_wmask0);
            mem_wr[sram_addr0] <= 1'b1;
         end else begin
            sram_dout0 <= mem_wr[sram_addr0] ? mem[sram_addr0]
                          : 32'h1000_0000 + {24'h0, sram_addr0};
         end
      end
   end

   function automatic cmd_t RD(input logic [7:0] a);
      return '{1'b1, 1'b0, 4'h0, a, 32'h0};
   endfunction
   function automatic cmd_t WR(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      return '{1'b1, 1'b1, m, a, d};
   endfunction
   function automatic cmd_t NO();
      return '{1'b0, 1'b0, 4'h0, 8'h0, 32'h0};
   endfunction

   task automatic add(input cmd_t ca, input cmd_t cb, input logic ear, input logic ebr,
                      input logic ecsb, input logic eweb, input logic [3:0] ewm,
                      input logic earv, input logic [31:0] eard,
                      input logic ebrv, input logic [31:0] ebrd);
      vec_t v;
      v.ca = ca;  v.cb = cb;  v.ear = ear; v.ebr = ebr; v.ecsb = ecsb; v.eweb = eweb;
      v.ewm = ewm; v.earv = earv; v.eard = eard; v.ebrv = ebrv; v.ebrd = ebrd;
      vecs.push_back(v);
   endtask

   task automatic drive(input cmd_t ca, input cmd_t cb);
      a_req_valid = ca.v; a_req_we = ca.we; a_req_wmask = ca.m;
      a_req_addr  = ca.a; a_req_wdata = ca.d;
      b_req_valid = cb.v; b_req_we = cb.we; b_req_wmask = cb.m;
      b_req_addr  = cb.a; b_req_wdata = cb.d;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(NO(), NO());

      // Reset and idle.
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_csb0", {31'h0, sram_csb0}, 1);
      chk("rst_web0", {31'h0, sram_web0}, 1);
      chk("rst_wmask0", {28'h0, sram_wmask0}, 0);
      chk("rst_addr0", {24'h0, sram_addr0}, 0);
      chk("rst_din0", sram_din0, 0);
      chk("rst_a_rsp_valid", {31'h0, a_rsp_valid}, 0);
      chk("rst_b_rsp_valid", {31'h0, b_rsp_valid}, 0);
      chk("rst_a_rsp_data", a_rsp_data, 0);
      chk("rst_b_rsp_data", b_rsp_data, 0);

      //   A cmd                      B cmd                     ar br cs we wm  arv ard           brv brd
      // First grant to A, then write-then-read of 0x10.
      add(WR(8'h10, 32'hDEADBEEF, 4'hF), RD(8'h40),        1, 0, 1, 1, 4'h0, 0, 0,            0, 0);
      add(RD(8'h10),                     RD(8'h40),        0, 1, 0, 0, 4'hF, 0, 0,            0, 0);
      add(RD(8'h10),                     NO(),             1, 0, 0, 1, 4'h0, 0, 0,            0, 0);
      add(NO(),                          NO(),             0, 0, 0, 1, 4'h0, 0, 0,            1, 32'h10000040);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 1, 32'hDEADBEEF, 0, 0);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 0, 0,            0, 0);
      // Byte-lane mask.
      add(WR(8'h20, 32'hFFFFFFFF, 4'hF), NO(),             1, 0, 1, 1, 4'h0, 0, 0,            0, 0);
      add(WR(8'h20, 32'h00000000, 4'h5), NO(),             1, 0, 0, 0, 4'hF, 0, 0,            0, 0);
      add(RD(8'h20),                     NO(),             1, 0, 0, 0, 4'h5, 0, 0,            0, 0);
      add(NO(),                          NO(),             0, 0, 0, 1, 4'h0, 0, 0,            0, 0);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 1, 32'hFF00FF00, 0, 0);
      // Zero-mask write leaves the word intact.
      add(NO(), WR(8'h20, 32'h12345678, 4'h0),             0, 1, 1, 1, 4'h0, 0, 0,            0, 0);
      add(NO(),                          RD(8'h20),        0, 1, 0, 0, 4'h0, 0, 0,            0, 0);
      add(NO(),                          NO(),             0, 0, 0, 1, 4'h0, 0, 0,            0, 0);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 0, 0,            1, 32'hFF00FF00);
      // Continuous contention: strict alternation.
      add(RD(8'h01),                     RD(8'h81),        1, 0, 1, 1, 4'h0, 0, 0,            0, 0);
      add(RD(8'h02),                     RD(8'h81),        0, 1, 0, 1, 4'h0, 0, 0,            0, 0);
      add(RD(8'h02),                     RD(8'h82),        1, 0, 0, 1, 4'h0, 1, 32'h10000001, 0, 0);
      add(RD(8'h03),                     RD(8'h82),        0, 1, 0, 1, 4'h0, 0, 0,            1, 32'h10000081);
      add(RD(8'h03),                     RD(8'h83),        1, 0, 0, 1, 4'h0, 1, 32'h10000002, 0, 0);
      add(RD(8'h04),                     RD(8'h83),        0, 1, 0, 1, 4'h0, 0, 0,            1, 32'h10000082);
      add(RD(8'h04),                     RD(8'h84),        1, 0, 0, 1, 4'h0, 1, 32'h10000003, 0, 0);
      add(NO(),                          RD(8'h84),        0, 1, 0, 1, 4'h0, 0, 0,            1, 32'h10000083);
      add(NO(),                          NO(),             0, 0, 0, 1, 4'h0, 1, 32'h10000004, 0, 0);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 0, 0,            1, 32'h10000084);
      // Lone requester B.
      add(NO(),                          RD(8'h90),        0, 1, 1, 1, 4'h0, 0, 0,            0, 0);
      add(NO(),                          RD(8'h91),        0, 1, 0, 1, 4'h0, 0, 0,            0, 0);
      add(NO(),                          RD(8'h92),        0, 1, 0, 1, 4'h0, 0, 0,            1, 32'h10000090);
      add(NO(),                          RD(8'h93),        0, 1, 0, 1, 4'h0, 0, 0,            1, 32'h10000091);
      add(NO(),                          RD(8'h94),        0, 1, 0, 1, 4'h0, 0, 0,            1, 32'h10000092);
      add(NO(),                          NO(),             0, 0, 0, 1, 4'h0, 0, 0,            1, 32'h10000093);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 0, 0,            1, 32'h10000094);
      add(NO(),                          NO(),             0, 0, 1, 1, 4'h0, 0, 0,            0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = 1'b0;
         row = i;
         drive(vecs[i].ca, vecs[i].cb);
         #1;
         chk("a_req_ready", {31'h0, a_req_ready}, {31'h0, vecs[i].ear});
         chk("b_req_ready", {31'h0, b_req_ready}, {31'h0, vecs[i].ebr});
         chk("sram_csb0", {31'h0, sram_csb0}, {31'h0, vecs[i].ecsb});
         chk("sram_web0", {31'h0, sram_web0}, {31'h0, vecs[i].eweb});
         chk("sram_wmask0", {28'h0, sram_wmask0}, {28'h0, vecs[i].ewm});
         chk("a_rsp_valid", {31'h0, a_rsp_valid}, {31'h0, vecs[i].earv});
         chk("a_rsp_data", a_rsp_data, vecs[i].eard);
         chk("b_rsp_valid", {31'h0, b_rsp_valid}, {31'h0, vecs[i].ebrv});
         chk("b_rsp_data", b_rsp_data, vecs[i].ebrd);
      end

      // Reset with two reads in flight; pointer is left at B before reset.
      row = 100;
      @(negedge clk); drive(RD(8'h05), NO()); #1;
      chk("mid_a_ready0", {31'h0, a_req_ready}, 1);
      row = 101;
      @(negedge clk); drive(RD(8'h06), NO()); #1;
      chk("mid_a_ready1", {31'h0, a_req_ready}, 1);
      chk("mid_csb0_busy", {31'h0, sram_csb0}, 0);
      row = 102;
      @(negedge clk); drive(NO(), NO()); rst = 1'b1; #1;
      chk("mid_pre_rst_a_rsp", a_rsp_data, 32'h10000005);
      row = 103;
      @(negedge clk); rst = 1'b0; drive(RD(8'h07), RD(8'h87)); #1;
      chk("mid_post_a_ready", {31'h0, a_req_ready}, 1);
      chk("mid_post_b_ready", {31'h0, b_req_ready}, 0);
      chk("mid_post_csb0", {31'h0, sram_csb0}, 1);
      chk("mid_post_web0", {31'h0, sram_web0}, 1);
      chk("mid_post_a_rsp_valid", {31'h0, a_rsp_valid}, 0);
      chk("mid_post_b_rsp_valid", {31'h0, b_rsp_valid}, 0);
      row = 104;
      @(negedge clk); drive(NO(), RD(8'h87)); #1;
      chk("mid_b_ready", {31'h0, b_req_ready}, 1);
      chk("mid_flush_a_rsp_valid", {31'h0, a_rsp_valid}, 0);
      chk("mid_flush_b_rsp_valid", {31'h0, b_rsp_valid}, 0);
      chk("mid_csb0_a_read", {31'h0, sram_csb0}, 0);
      row = 105;
      @(negedge clk); drive(NO(), NO()); #1;
      chk("mid_a_rsp_valid", {31'h0, a_rsp_valid}, 1);
      chk("mid_a_rsp_data", a_rsp_data, 32'h10000007);
      chk("mid_b_rsp_idle", {31'h0, b_rsp_valid}, 0);
      row = 106;
      @(negedge clk); #1;
      chk("mid_b_rsp_valid", {31'h0, b_rsp_valid}, 1);
      chk("mid_b_rsp_data", b_rsp_data, 32'h10000087);
      chk("mid_a_rsp_quiet", {31'h0, a_rsp_valid}, 0);
      row = 107;
      @(negedge clk); #1;
      chk("mid_tail_a_rsp", {31'h0, a_rsp_valid}, 0);
      chk("mid_tail_b_rsp", {31'h0, b_rsp_valid}, 0);
      chk("mid_tail_csb0", {31'h0, sram_csb0}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
